vic_vect_ctrl: RTL
==================

# vic_vect_ctrl

Vectored-interrupt priority controller sitting between `int_gen` and the CPU-facing register block. It takes the masked `IRQStatus` vector and up to 16 vector slot configurations, then selects the highest-priority pending vectored interrupt. It presents that slot's handler address and an IRQ request. It also tracks nested in-service priority levels, driven by CPU acknowledge (read of VICVectAddr) and end-of-interrupt (write of VICVectAddr) strobes.

## Interface
- `NUM_VECT`, 16: number of vectored slots; slot 0 has the highest priority. Supported range 1–16.
- `SRC_W`, 5: width of the source index; there are 2^SRC_W = 32 sources.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `IRQStatus` in 32: masked IRQ status from `int_gen`.
- `top_reg_VICVectCntl` in NUM_VECT*6: per slot i, bits [6i+5] = enable and [6i+4:6i] = source number.
- `top_reg_VICVectAddr` in NUM_VECT*32: per-slot handler address, slot i at bits [32i+31:32i].
- `top_reg_VICDefVectAddr` in 32: address for non-vectored IRQs.
- `vect_rd` in 1: one-cycle strobe; CPU read of VICVectAddr (acknowledge).
- `vect_wr` in 1: one-cycle strobe; CPU write of VICVectAddr (end of interrupt).
- `vect_irq` out 1: IRQ request to the CPU, active-high, registered.
- `vect_reg_VICVectAddr` out 32: address returned on a VICVectAddr read, registered.
- `vect_cur_prio` out 5: current in-service level, 0–16; 17 means idle. Registered.

## Operation
Levels:
- Levels 0..NUM_VECT-1 are the vectored slots.
- Level 16 is the default (non-vectored) level.
- Code 17 means no level is in service.

Per-slot hit and default request:
- `hit[i]` = enable_i AND `IRQStatus[src_i]`.
- `def_req` = OR of `IRQStatus` bits not claimed by any enabled slot.
- Several slots may name the same source; each of them hits.

In-service tracking:
- In-service state is a 17-bit register `act`. Bit L set means level L is in service.
- `cur` = index of the lowest set bit of `act`, or 17 if `act` is empty.

Candidate selection:
- Candidate = the lowest i with `hit[i]` and i < `cur`.
- Otherwise, level 16 if `def_req` and `cur` == 17.
- Otherwise, none.
- Consequence: a default IRQ never nests, and a vectored IRQ only preempts a strictly lower priority.

Output register, each cycle:
- Candidate present: `vect_irq`=1, `vect_reg_VICVectAddr` = the slot address (or DefVectAddr for level 16), `cand_q` = candidate level.
- No candidate: `vect_irq`=0 and the address is taken from the in-service level `cur`: VectAddr[cur], DefVectAddr if `cur`=16, or 0 if idle.

`vect_rd` (acknowledge):
- If `vect_irq`=1: set `act[cand_q]`.
- If `vect_irq`=0: no state change; the CPU simply reads the held address.

`vect_wr` (end of interrupt):
- Clears the lowest set bit of `act`.
- Ignored if `act` is empty.
- The write data is don't-care.

Simultaneous `vect_rd` and `vect_wr`: the pop is performed and the read is ignored.

Config changes:
- `VectCntl`/`VectAddr` changes take effect on the next candidate evaluation.
- They do not alter `act`.
- A disabled slot that is in service stays in service until its EOI.

Nesting depth: at most 17 levels, bounded by construction; overflow is impossible.

## Timing
- Reset values: `act`=0, `vect_irq`=0, `vect_reg_VICVectAddr`=0, `vect_cur_prio`=17, `cand_q`=0.
- `IRQStatus` or config change sampled at edge n → outputs updated at edge n+1 (1-cycle latency).
- `vect_rd` at edge n with `vect_irq`=1:
  - `act` is updated at edge n.
  - `vect_irq` is forced to 0 for the cycle following edge n; the address register loads VectAddr[`cand_q`].
  - Re-evaluated outputs appear at edge n+1.
  - This guarantees that two back-to-back reads never push the same level.
- `vect_wr` at edge n:
  - `act` is updated at edge n.
  - `vect_irq` is forced to 0 for the following cycle.
  - Re-evaluated outputs appear at edge n+1.
- `vect_cur_prio` reflects `act` one cycle after the update.
- `rst` is asserted mid-service: all state returns to reset values on that edge, and pending IRQs re-present 1 cycle after `rst` deasserts.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `IRQStatus`=0xFFFFFFFF → `vect_irq`=0, address=0, `vect_cur_prio`=17 throughout; with no slots enabled, `vect_irq`=1 and address=Def one cycle after release.
- **Single vectored IRQ.** Slot 3 = {en, src 7}, address 0x1000. `IRQStatus`=0x80 → `vect_irq`=1 with address 0x1000 next cycle. `vect_rd` → `vect_irq`=0 and `vect_cur_prio`=3. `vect_wr` → `vect_cur_prio`=17.
- **Nesting.** Slot 5 in service. Slot 2 (src 1, address 0x2000) fires → `vect_irq`=1 with 0x2000. `vect_rd` → `vect_cur_prio`=2. Slot 9 firing meanwhile → no IRQ. First `vect_wr` → `vect_cur_prio`=5; second → 17.
- **Priority and default.** Slots 0 (src 4) and 1 (src 4) both enabled, `IRQStatus`=0x11 → slot 0 address. After acknowledge, bit 0 (unclaimed) must not raise an IRQ until `act` is empty, then Def is presented.
- **Boundary strobes.** `vect_wr` with `act`=0 → no change. `vect_rd` with `vect_irq`=0 → no change. Same-cycle rd and wr with `cur`=4 → pop only; `cur` becomes the next-lower active level (or 17).
- **Mid-service reset.** Three nested levels active, assert `rst` → `act`=0 and `vect_cur_prio`=17. The highest pending IRQ re-presents 1 cycle after release.

Source files
------------

// File: rtl/vic_vect_ctrl.sv
// Vectored interrupt priority controller: picks the highest-priority pending slot
// above the current in-service level, presents its handler address, tracks nesting.
module vic_vect_ctrl #(
    parameter int unsigned NUM_VECT = 16,
    parameter int unsigned SRC_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(2**SRC_W)-1:0]   IRQStatus,
    input  logic [NUM_VECT*6-1:0]   top_reg_VICVectCntl,
    input  logic [NUM_VECT*32-1:0]  top_reg_VICVectAddr,
    input  logic [31:0]             top_reg_VICDefVectAddr,
    input  logic                    vect_rd,
    input  logic                    vect_wr,
    output logic                    vect_irq,
    output logic [31:0]             vect_reg_VICVectAddr,
    output logic [4:0]              vect_cur_prio
);
    localparam int unsigned NSRC     = 2**SRC_W;
    localparam logic [4:0]  LVL_DEF  = 5'd16;
    localparam logic [4:0]  LVL_IDLE = 5'd17;

    function automatic logic [4:0] lowest_lvl(input logic [16:0] act);
        logic [4:0] lvl;
        lvl = LVL_IDLE;
        for (int unsigned i = 17; i > 0; i--) begin
            if (act[i-1]) lvl = 5'(i-1);
        end
        return lvl;
    endfunction

    logic [16:0]         act_q, act_d;
    logic                irq_q, irq_d;
    logic [31:0]         addr_q, addr_d;
    logic [4:0]          prio_q, prio_d;
    logic [4:0]          cand_q, cand_d;

    logic [NUM_VECT-1:0] hit;
    logic [NSRC-1:0]     claimed;
    logic                def_req;
    logic [4:0]          cur;
    logic [4:0]          cand;
    logic                cand_vld;
    logic                pop;
    logic                push;
    logic [4:0]          sel_lvl;

    always_comb begin
        hit     = '0;
        claimed = '0;
        for (int unsigned i = 0; i < NUM_VECT; i++) begin
            hit[i] = top_reg_VICVectCntl[6*i+5] & IRQStatus[top_reg_VICVectCntl[6*i +: SRC_W]];
            if (top_reg_VICVectCntl[6*i+5]) claimed[top_reg_VICVectCntl[6*i +: SRC_W]] = 1'b1;
        end
        def_req = |(IRQStatus & ~claimed);
    end

    always_comb begin
        cur      = lowest_lvl(act_q);
        cand     = '0;
        cand_vld = 1'b0;
        for (int unsigned i = NUM_VECT; i > 0; i--) begin
            if (hit[i-1] && (5'(i-1) < cur)) begin
                cand     = 5'(i-1);
                cand_vld = 1'b1;
            end
        end
        // The default level only presents when nothing at all is in service.
        if (!cand_vld && def_req && (cur == LVL_IDLE)) begin
            cand     = LVL_DEF;
            cand_vld = 1'b1;
        end
    end

    always_comb begin
        // A write always wins over a simultaneous read; an empty-stack write is a no-op.
        pop   = vect_wr && (|act_q);
        push  = vect_rd && irq_q && !vect_wr;
        act_d = act_q;
        if (pop)       act_d = act_q & (act_q - 17'd1);
        else if (push) act_d = act_q | (17'd1 << cand_q);

        if (push)          sel_lvl = cand_q;
        else if (pop)      sel_lvl = lowest_lvl(act_d);
        else if (cand_vld) sel_lvl = cand;
        else               sel_lvl = cur;

        addr_d = '0;
        for (int unsigned i = 0; i < NUM_VECT; i++) begin
            if (sel_lvl == 5'(i)) addr_d = top_reg_VICVectAddr[32*i +: 32];
        end
        if (sel_lvl == LVL_DEF) addr_d = top_reg_VICDefVectAddr;

        irq_d  = cand_vld && !pop && !push;
        cand_d = irq_d ? cand : cand_q;
        prio_d = cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= '0;
            irq_q  <= 1'b0;
            addr_q <= '0;
            prio_q <= LVL_IDLE;
            cand_q <= '0;
        end else begin
            act_q  <= act_d;
            irq_q  <= irq_d;
            addr_q <= addr_d;
            prio_q <= prio_d;
            cand_q <= cand_d;
        end
    end

    assign vect_irq             = irq_q;
    assign vect_reg_VICVectAddr = addr_q;
    assign vect_cur_prio        = prio_q;

endmodule
